// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner.
package truth_table_scanner_pkg;

   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned TABLE_W = 16;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned SET_W   = 4;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StSample,
      StDone
   } state_t;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter that times the settle window of each vector.
module settle_timer
   import truth_table_scanner_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [SET_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [SET_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 input vectors of a 4-input function, waits for it to settle and
// captures its output into a truth table with a running ones count.
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               x,
   output logic               a,
   output logic               b,
   output logic               c,
   output logic               d,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [TABLE_W-1:0] table_o,
   output logic [CNT_W-1:0]   ones_cnt
);

   // Timer is loaded with SETTLE_CYC-1 so that SETTLE spans exactly SETTLE_CYC cycles.
   localparam logic [SET_W-1:0] SettleLoad =
      (SETTLE_CYC == 0) ? '0 : SET_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VEC - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_vec;
   logic [TABLE_W-1:0] r_table;
   logic [CNT_W-1:0]   r_ones;
   logic               r_aborted;
   logic               w_busy;
   logic               w_zero;

   assign w_busy = (r_state == StDrive) || (r_state == StSettle) || (r_state == StSample);

   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (r_state == StDrive),
      .i_load_val (SettleLoad),
      .i_en       (r_state == StSettle),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_idx     <= '0;
         r_vec     <= '0;
         r_table   <= '0;
         r_ones    <= '0;
         r_aborted <= 1'b0;
      end else if (abort && w_busy) begin
         // Abort beats any capture in the same cycle, including the final one.
         r_state   <= StIdle;
         r_vec     <= '0;
         r_aborted <= 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_table   <= '0;
                  r_ones    <= '0;
                  r_aborted <= 1'b0;
                  r_idx     <= '0;
                  r_vec     <= '0;
                  r_state   <= StDrive;
               end
            end
            StDrive: begin
               r_state <= (SETTLE_CYC == 0) ? StSample : StSettle;
            end
            StSettle: begin
               if (w_zero) r_state <= StSample;
            end
            StSample: begin
               r_table[r_idx] <= x;
               if (x) r_ones <= r_ones + 1'b1;
               if (r_idx == LastIdx) begin
                  r_vec   <= '0;
                  r_state <= StDone;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_vec   <= r_idx + 1'b1;
                  r_state <= StDrive;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign {a, b, c, d} = r_vec;
   assign busy         = w_busy;
   assign done         = (r_state == StDone);
   assign aborted      = r_aborted;
   assign table_o      = r_table;
   assign ones_cnt     = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Checks two scanners (SETTLE_CYC=2 and 0) against a cycle-level arithmetic model.
module tb_truth_table_scanner;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       start_s = '0;
   logic [1:0]       abort_s = '0;
   logic [1:0]       x_s;
   logic [1:0]       oa, ob, oc, od;
   logic [1:0]       busy_s, done_s, abrt_s;
   logic [1:0][15:0] tab_s;
   logic [1:0][4:0]  ones_s;

   int          total = 0;
   int          bad = 0;
   int          mode = 0;
   logic [15:0] rtab = '0;
   int          st[2] = '{0, 0};
   logic [3:0]  pv[2] = '{4'h0, 4'h0};
   logic        pb[2] = '{1'b0, 1'b0};

   truth_table_scanner #(.SETTLE_CYC(2)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .x(x_s[0]),
      .a(oa[0]), .b(ob[0]), .c(oc[0]), .d(od[0]), .busy(busy_s[0]), .done(done_s[0]),
      .aborted(abrt_s[0]), .table_o(tab_s[0]), .ones_cnt(ones_s[0])
   );

   truth_table_scanner #(.SETTLE_CYC(0)) u_dut_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .x(x_s[1]),
      .a(oa[1]), .b(ob[1]), .c(oc[1]), .d(od[1]), .busy(busy_s[1]), .done(done_s[1]),
      .aborted(abrt_s[1]), .table_o(tab_s[1]), .ones_cnt(ones_s[1])
   );

   always #5 clk = ~clk;

   function automatic int settle_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   function automatic logic fx(input int m, input logic [15:0] rt, input logic [3:0] i);
      case (m)
         0: return ^i;
         1: return 1'b1;
         2: return 1'b0;
         3: return i[3] & i[2];
         4: return (i < 4'd3);
         default: return rt[i];
      endcase
   endfunction

   function automatic logic [15:0] full_tab(input int m, input logic [15:0] rt);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = fx(m, rt, 4'(i));
      return r;
   endfunction

   function automatic logic [15:0] mask(input int k);
      logic [16:0] m;
      m = (17'h1 << k) - 17'h1;
      return m[15:0];
   endfunction

   // The function under test shows the wrong value until its inputs have been stable
   // for SETTLE_CYC+1 cycles, so sampling early corrupts the captured table.
   always_comb begin
      x_s = '0;
      for (int u = 0; u < 2; u++) begin
         x_s[u] = (st[u] >= settle_of(u) + 1) ? fx(mode, rtab, {oa[u], ob[u], oc[u], od[u]})
                                               : !fx(mode, rtab, {oa[u], ob[u], oc[u], od[u]});
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (({oa[u], ob[u], oc[u], od[u]} != pv[u]) || (busy_s[u] && !pb[u])) st[u] <= 0;
         else if (st[u] < 1000) st[u] <= st[u] + 1;
         pv[u] <= {oa[u], ob[u], oc[u], od[u]};
         pb[u] <= busy_s[u];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int u);
      chk("rst_busy", busy_s[u], 0);
      chk("rst_done", done_s[u], 0);
      chk("rst_abrt", abrt_s[u], 0);
      chk("rst_vec", {oa[u], ob[u], oc[u], od[u]}, 0);
      chk("rst_tab", tab_s[u], 0);
      chk("rst_ones", ones_s[u], 0);
   endtask

   task automatic kick(input int u, input bit hold, input bit with_abort);
      @(negedge clk);
      start_s[u] = 1'b1;
      abort_s[u] = with_abort;
      @(posedge clk);
      #1;
      abort_s[u] = 1'b0;
      if (!hold) start_s[u] = 1'b0;
   endtask

   // Called #1 after the edge that accepted start; t counts edges since then.
   task automatic run_checked(input int u, input int abort_t, input int stop_t);
      int          per;
      int          n;
      int          comp;
      logic [15:0] full;
      logic [15:0] part;
      per  = settle_of(u) + 2;
      n    = 16 * per;
      full = full_tab(mode, rtab);
      for (int t = 0; t <= n + 1; t++) begin
         comp = (t < n) ? t / per : 16;
         part = full & mask(comp);
         if (t < n) begin
            chk("busy", busy_s[u], 1);
            chk("done", done_s[u], 0);
            chk("vec", {oa[u], ob[u], oc[u], od[u]}, t / per);
         end else begin
            chk("end_busy", busy_s[u], 0);
            chk("end_done", done_s[u], (t == n) ? 1 : 0);
            chk("end_vec", {oa[u], ob[u], oc[u], od[u]}, 0);
         end
         chk("abrt", abrt_s[u], 0);
         chk("tab", tab_s[u], part);
         chk("ones", ones_s[u], $countones(part));
         if (t == stop_t) return;
         if (t == abort_t) begin
            @(negedge clk);
            abort_s[u] = 1'b1;
            @(posedge clk);
            #1;
            abort_s[u] = 1'b0;
            part = full & mask(t / per);
            chk("ab_flag", abrt_s[u], 1);
            chk("ab_busy", busy_s[u], 0);
            chk("ab_vec", {oa[u], ob[u], oc[u], od[u]}, 0);
            chk("ab_tab", tab_s[u], part);
            chk("ab_ones", ones_s[u], $countones(part));
            repeat (2 * per) begin
               @(posedge clk);
               #1;
               chk("ab_nodone", done_s[u], 0);
               chk("ab_idle", busy_s[u], 0);
               chk("ab_hold", tab_s[u], part);
            end
            return;
         end
         if (t < n + 1) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      int u;
      int per;
      int abt;
      #1;
      chk_zero(0);
      chk_zero(1);
      @(negedge clk);
      rst_n = 1'b1;

      // Parity function, default settle
      mode = 0;
      kick(0, 0, 0);
      run_checked(0, -1, -1);
      chk("xor_tab", tab_s[0], 16'h6996);
      chk("xor_ones", ones_s[0], 8);

      // Constant functions, zero settle
      mode = 1;
      kick(1, 0, 0);
      run_checked(1, -1, -1);
      chk("one_tab", tab_s[1], 16'hFFFF);
      chk("one_ones", ones_s[1], 16);
      mode = 2;
      kick(1, 0, 0);
      run_checked(1, -1, -1);
      chk("zero_tab", tab_s[1], 16'h0000);

      // Aborts during vector 5
      mode = 3;
      kick(0, 0, 0);
      run_checked(0, 5 * 4 + 1, -1);
      chk("and_tab", tab_s[0], 16'h0000);
      mode = 4;
      kick(0, 0, 0);
      run_checked(0, 5 * 4 + 3, -1);
      chk("lt3_tab", tab_s[0], 16'h0007);
      chk("lt3_ones", ones_s[0], 3);

      // Abort while idle is ignored
      @(negedge clk);
      abort_s[0] = 1'b1;
      @(posedge clk);
      #1;
      abort_s[0] = 1'b0;
      chk("idle_ab_flag", abrt_s[0], 1);
      chk("idle_ab_busy", busy_s[0], 0);
      chk("idle_ab_tab", tab_s[0], 16'h0007);

      // Start and abort together: start wins, aborted clears
      mode = 0;
      kick(0, 0, 1);
      run_checked(0, -1, -1);

      // Abort coinciding with the final sample
      mode = 1;
      kick(1, 0, 0);
      run_checked(1, 15 * 2 + 1, -1);
      chk("last_ab_tab", tab_s[1], 16'h7FFF);
      mode = 5;
      rtab = 16'hFFFF;
      kick(0, 0, 0);
      run_checked(0, 15 * 4 + 3, -1);
      chk("last_ab_tab2", tab_s[0], 16'h7FFF);

      // Start held high: one scan, then exactly one more from IDLE
      rtab = 16'(($urandom));
      kick(0, 1, 0);
      run_checked(0, -1, -1);
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      run_checked(0, -1, -1);
      chk("hold_tab", tab_s[0], rtab);

      // Reset in the middle of vector 9
      mode = 0;
      kick(0, 0, 0);
      run_checked(0, -1, 9 * 4 + 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero(0);
      @(negedge clk);
      rst_n = 1'b1;
      kick(0, 0, 0);
      run_checked(0, -1, -1);
      chk("post_rst_tab", tab_s[0], 16'h6996);

      // Randomized scans and abort points
      for (int k = 0; k < 8; k++) begin
         u    = int'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 5));
         rtab = 16'($urandom);
         per  = settle_of(u) + 2;
         abt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16 * per - 1)) : -1;
         kick(u, 0, 0);
         run_checked(u, abt, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: idle cycles between driving a vector and sampling x; legal range 0..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  scan request, level-sampled while idle.
REQ-005 SHALL have port abort  input  1  cancel a scan in progress.
REQ-006 SHALL have port x  input  1  output of the 4-input combinational function under test.
REQ-007 SHALL have ports a, b, c, d  output  1 each  function inputs; {a,b,c,d} = vector index, a is MSB.
REQ-008 SHALL have port busy  output  1  high while a scan is running.
REQ-009 SHALL have port done  output  1  one-cycle pulse on scan completion.
REQ-010 SHALL have port aborted  output  1  sticky flag: the last scan was cancelled.
REQ-011 SHALL have port table_o  output  16  captured truth table; bit i = x for vector i.
REQ-012 SHALL have port ones_cnt  output  5  number of 1 bits in table_o (0..16).

Function
REQ-013 SHALL implement the states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: on the first edge with start=1, SHALL clear table_o, ones_cnt and aborted, set vector index to 0 and enter DRIVE.
REQ-015 DRIVE SHALL last 1 cycle, with {a,b,c,d} = index. It SHALL then enter SETTLE, or SAMPLE if SETTLE_CYC=0.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles, counted by a down-counter, and then enter SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle; on the edge leaving it, x SHALL be written to table_o[index] and ones_cnt incremented if x=1.
REQ-018 After SAMPLE: if index=15, the block SHALL enter DONE; otherwise index SHALL increment and the block SHALL enter DRIVE.
REQ-019 DONE SHALL last 1 cycle with done=1, then return to IDLE. table_o and ones_cnt SHALL hold until the next accepted start.
REQ-020 Latency: done SHALL be high in the cycle after the 16*(SETTLE_CYC+2)-th rising edge counted from the edge that accepted start (64 edges at default).
REQ-021 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-022 {a,b,c,d} SHALL be 0000 in IDLE and DONE, and SHALL be stable for the whole DRIVE..SAMPLE span of each vector.
REQ-023 start SHALL be ignored while busy=1 or in DONE; there is no queuing.
REQ-024 abort=1 while busy SHALL, at the next edge, go to IDLE, set aborted=1 and assert no done pulse. Already-captured bits SHALL be kept; uncaptured bits SHALL remain 0.
REQ-025 If abort and start are both 1 in IDLE, start SHALL win and aborted SHALL be cleared. abort in IDLE or DONE SHALL be ignored.
REQ-026 If abort coincides with the final SAMPLE, abort SHALL win: bit 15 is not written and done is not pulsed.
REQ-027 The index SHALL never wrap past 15 within one scan.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, index=0, settle counter=0, a=b=c=d=0, busy=0, done=0, aborted=0, table_o=16'h0000 and ones_cnt=0, regardless of the clock.
REQ-029 Reset mid-scan SHALL discard the scan with no done pulse. The first start after rst_n rises SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the state encoding (typedef), NUM_VEC=16, IDX_W=4, TABLE_W=16 and CNT_W=5.
REQ-031 The settle down-counter SHALL be a sub-module named settle_timer (load, enable, zero flag). All other logic SHALL stay in truth_table_scanner.

Verification
REQ-032 Model x=a^b^c^d, SETTLE_CYC=2, pulse start -> done 64 edges later; table_o=16'h6996; ones_cnt=8; busy=0.
REQ-033 Model x=1 with SETTLE_CYC=0 -> done after 32 edges; table_o=16'hFFFF; ones_cnt=16. Model x=0 -> 16'h0000, ones_cnt=0.
REQ-034 Model x=a&b, abort during vector 5 -> aborted=1, no done pulse, table_o=16'h0000. Repeat with x=(index<3) -> table_o=16'h0007, ones_cnt=3.
REQ-035 start held high through an entire scan -> exactly one scan runs, then a second scan starts from IDLE after DONE; the result is identical.
REQ-036 rst_n low at vector 9, then high, then start -> all outputs go to zero immediately; the next full scan gives the correct table.
REQ-037 A checker SHALL confirm {a,b,c,d} is constant between DRIVE and SAMPLE, and that x is sampled SETTLE_CYC+1 edges after each vector is driven.
